lut_layer_sequencer: RTL and testbench

LUT_LAYER_SEQUENCER -- requirements
Module: lut_layer_sequencer

---
 rtl/lut_layer_sequencer_pkg.sv | 35 +++
 rtl/lut_addr_mux.sv | 25 ++
 rtl/lut_layer_sequencer.sv | 107 ++++++++++
 tb/tb_lut_layer_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_layer_sequencer_pkg.sv
// Shared defaults, FSM states and fan-in wiring for the LUT layer sequencer.
// CONN maps (neuron, fan-in slot) to the input feature feeding that slot.
package lut_layer_sequencer_pkg;

  localparam int N_IN_DEF   = 8;
  localparam int IN_BW_DEF  = 2;
  localparam int FAN_IN_DEF = 4;
  localparam int N_OUT_DEF  = 8;
  localparam int OUT_BW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  // Wiring table for the default geometry: CONN[n][k] = (n+k) mod N_IN.
  localparam int CONN [N_OUT_DEF][FAN_IN_DEF] = '{
    '{0, 1, 2, 3},
    '{1, 2, 3, 4},
    '{2, 3, 4, 5},
    '{3, 4, 5, 6},
    '{4, 5, 6, 7},
    '{5, 6, 7, 0},
    '{6, 7, 0, 1},
    '{7, 0, 1, 2}
  };

  // Same wiring rule, usable for any parameterised geometry.
  function automatic int conn(int n, int k, int n_in);
    return (n + k) % n_in;
  endfunction

endpackage

// File: rtl/lut_addr_mux.sv
// Combinational LUT address builder: picks the FAN_IN features of neuron
// from the latched vector. Ports: neuron, vec in; addr out.
module lut_addr_mux
  import lut_layer_sequencer_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int IN_BW  = IN_BW_DEF,
  parameter int FAN_IN = FAN_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int NW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic [NW-1:0]           neuron,
  input  logic [N_IN*IN_BW-1:0]   vec,
  output logic [FAN_IN*IN_BW-1:0] addr
);

  always_comb begin
    addr = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      addr[k*IN_BW +: IN_BW] =
        vec[conn(int'(neuron), k, N_IN)*IN_BW +: IN_BW];
    end
  end

endmodule

// File: rtl/lut_layer_sequencer.sv
// Sequences one LUT-network layer: latches a vector, reads each neuron's
// table from an external LUT bank, assembles and presents the layer result.
// Ports: clk, rst; in_valid/in_ready/in_data; lut_req/lut_neuron/lut_addr,
// lut_data; out_valid/out_ready/out_data.
module lut_layer_sequencer
  import lut_layer_sequencer_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int IN_BW  = IN_BW_DEF,
  parameter int FAN_IN = FAN_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int OUT_BW = OUT_BW_DEF,
  localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*IN_BW-1:0]     in_data,
  output logic                      lut_req,
  output logic [NW-1:0]             lut_neuron,
  output logic [FAN_IN*IN_BW-1:0]   lut_addr,
  input  logic [OUT_BW-1:0]         lut_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*OUT_BW-1:0]   out_data
);

  state_t                    state;
  state_t                    state_nx;
  logic [NW-1:0]             cnt;
  logic [N_IN*IN_BW-1:0]     vec;
  logic                      req_v;
  logic [NW-1:0]             req_n;
  logic [N_OUT*OUT_BW-1:0]   out_q;
  logic                      accept;
  logic                      last;

  assign accept     = in_valid && in_ready;
  assign last       = (cnt == NW'(N_OUT - 1));
  assign lut_neuron = cnt;
  assign out_data   = out_q;

  lut_addr_mux #(
    .N_IN   (N_IN),
    .IN_BW  (IN_BW),
    .FAN_IN (FAN_IN),
    .N_OUT  (N_OUT),
    .NW     (NW)
  ) u_mux (
    .neuron (cnt),
    .vec    (vec),
    .addr   (lut_addr)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    lut_req   = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        lut_req = 1'b1;
        if (last) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
      req_v <= 1'b0;
      req_n <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      // req_v/req_n track the request whose data returns next cycle;
      // clearing req_v on reset drops any return still in flight.
      req_v <= lut_req;
      req_n <= cnt;
      if (accept) begin
        vec <= in_data;
        cnt <= '0;
      end else if (lut_req) begin
        cnt <= last ? '0 : cnt + NW'(1);
      end
      if (req_v) begin
        out_q[req_n*OUT_BW +: OUT_BW] <= lut_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer with a stub LUT bank and
// a behavioural model of the layer result.
module tb_lut_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        lut_req;
  logic [2:0]  lut_neuron;
  logic [7:0]  lut_addr;
  logic [1:0]  lut_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  bit mode     = 1'b0;
  logic [1:0] tbl [0:7][0:255];

  lut_layer_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lut_req    (lut_req),
    .lut_neuron (lut_neuron),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mode) lut_data <= tbl[lut_neuron][lut_addr];
    else      lut_data <= lut_neuron[1:0];
  end

  function automatic logic [7:0] model_addr(logic [15:0] v, int n);
    logic [7:0] a;
    int f;
    a = '0;
    for (int k = 0; k < 4; k++) begin
      f = (n + k) % 8;
      a[2*k +: 2] = v[2*f +: 2];
    end
    return a;
  endfunction

  function automatic logic [15:0] exp_out(logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      if (mode) r[2*n +: 2] = tbl[n][model_addr(v, n)];
      else      r[2*n +: 2] = 2'(n % 4);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, then completes the handshake.
  task automatic collect(output bit ok, output logic [15:0] d);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
    d = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    total++;
    if (lut_req !== 1'b0) $display("FAIL reset_lut_req got %b want 0", lut_req);
    else pass_cnt++;
    total++;
    if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    mode = 1'b0;
    in_data  = 16'h0000;
    in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL lat_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (lut_req !== 1'b1 || lut_neuron !== 3'(i))
        $display("FAIL lat_issue%0d got req=%b n=%0d want req=1 n=%0d", i, lut_req, lut_neuron, i);
      else pass_cnt++;
      tick();
    end
    total++;
    if (lut_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL lat_drain got req=%b ov=%b want 0 0", lut_req, out_valid);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hE4E4)
      $display("FAIL lat_out got ov=%b d=%h want 1 e4e4", out_valid, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL lat_idle got ov=%b ir=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_addressing();
    logic [7:0] a [8];
    bit ok;
    logic [15:0] d;
    mode = 1'b0;
    send(16'h0003);
    for (int i = 0; i < 8; i++) begin
      a[i] = lut_addr;
      tick();
    end
    total++;
    if (a[0] !== 8'h03) $display("FAIL addr_n0 got %h want 03", a[0]);
    else pass_cnt++;
    total++;
    if (a[5] !== 8'hC0) $display("FAIL addr_n5 got %h want c0", a[5]);
    else pass_cnt++;
    for (int n = 1; n < 5; n++) begin
      total++;
      if (a[n] !== 8'h00) $display("FAIL addr_n%0d got %h want 00", n, a[n]);
      else pass_cnt++;
    end
    collect(ok, d);
    for (int r = 0; r < 4; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      send(v);
      for (int i = 0; i < 8; i++) begin
        total++;
        if (lut_addr !== model_addr(v, i))
          $display("FAIL addr_rand n%0d got %h want %h", i, lut_addr, model_addr(v, i));
        else pass_cnt++;
        tick();
      end
      collect(ok, d);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va, vb, ea, eb, d;
    bit ok;
    mode = 1'b1;
    va = 16'($urandom);
    vb = 16'($urandom);
    ea = exp_out(va);
    eb = exp_out(vb);
    send(va);
    for (int i = 0; i < 9; i++) tick();
    in_data  = vb;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== ea || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got ov=%b d=%h ir=%b want 1 %h 0", i, out_valid, out_data, in_ready, ea);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    collect(ok, d);
    total++;
    if (!ok || d !== eb) $display("FAIL bp_second got ok=%b d=%h want 1 %h", ok, d, eb);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int pts [4] = '{4, 8, 9, 10};
    logic [15:0] v, d;
    bit ok, seen;
    mode = 1'b1;
    foreach (pts[j]) begin
      send(16'($urandom));
      for (int i = 1; i < pts[j]; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (lut_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL rstmid%0d got req=%b ov=%b ir=%b want 0 0 1", pts[j], lut_req, out_valid, in_ready);
      else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) seen = 1'b1;
        tick();
      end
      total++;
      if (seen || out_data !== 16'h0000)
        $display("FAIL rstmid%0d_quiet got ov_seen=%b d=%h want 0 0000", pts[j], seen, out_data);
      else pass_cnt++;
      v = 16'($urandom);
      send(v);
      collect(ok, d);
      total++;
      if (!ok || d !== exp_out(v))
        $display("FAIL rstmid%0d_next got ok=%b d=%h want 1 %h", pts[j], ok, d, exp_out(v));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    int acc [$];
    int got;
    bit acc_now;
    mode = 1'b1;
    got = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'($urandom);
    for (int c = 0; c < 120 && got < 6; c++) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        exp_q.push_back(exp_out(in_data));
        acc.push_back(cyc);
      end
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_spurious got d=%h want none", out_data);
        end else begin
          if (out_data !== exp_q[0])
            $display("FAIL b2b_res%0d got %h want %h", got, out_data, exp_q[0]);
          else pass_cnt++;
          void'(exp_q.pop_front());
        end
        got++;
      end
      tick();
      if (acc_now) in_data = 16'($urandom);
    end
    total++;
    if (got != 6) $display("FAIL b2b_count got %0d want 6", got);
    else pass_cnt++;
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != 11)
        $display("FAIL b2b_period%0d got %0d want 11", i, acc[i] - acc[i-1]);
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 8; n++)
      for (int a = 0; a < 256; a++)
        tbl[n][a] = 2'($urandom);
    #1;
    test_reset();
    test_latency();
    test_addressing();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
